// File: rtl/prog_loader.sv
// Framed program loader: parses A5/count/payload/checksum frames from the UART byte
// stream, writes little-endian words to instruction memory and holds the CPU until a good frame.
module prog_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_041_600
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned WL_W      = ADDR_W + 1;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned MAX_WORDS = ((32'(1) << ADDR_W) > 32'd255) ? 32'd255 : (32'(1) << ADDR_W);
  localparam logic [7:0]  SYNC      = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_CSUM} state_e;

  state_e            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [WL_W-1:0]   words_q, words_d;
  logic              timed_out;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      words_q     <= words_d;
    end
  end

  // Frame parser, inter-byte timeout and output next-state
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    words_d     = words_q;
    timed_out   = 1'b0;

    if (state_q != S_IDLE) begin
      if (rx_dv) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        timed_out = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (timed_out) begin
      load_err_d = 1'b1;
      tmo_d      = '0;
      state_d    = S_IDLE;
    end else if (rx_dv) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_byte == SYNC) begin
            load_err_d = 1'b0;
            words_d    = '0;
            idx_d      = '0;
            csum_d     = '0;
            tmo_d      = '0;
            cpu_hold_d = 1'b1;
            state_d    = S_COUNT;
          end
        end
        S_COUNT: begin
          if (32'(rx_byte) > MAX_WORDS) begin
            load_err_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            n_d     = rx_byte;
            csum_d  = rx_byte;
            state_d = (rx_byte == 8'd0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_q ^ rx_byte;
          idx_d  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: asm_d[7:0]   = rx_byte;
            2'd1: asm_d[15:8]  = rx_byte;
            2'd2: asm_d[23:16] = rx_byte;
            2'd3: begin
              mem_we_d   = 1'b1;
              mem_addr_d = words_q[ADDR_W-1:0];
              mem_din_d  = {rx_byte, asm_q};
              words_d    = words_q + WL_W'(1);
              if (32'(words_q) + 32'd1 == 32'(n_q)) state_d = S_CSUM;
            end
            default: ;
          endcase
        end
        S_CSUM: begin
          if (rx_byte == csum_q) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Framed program loader between the UART receiver and the instruction memory. It consumes the receiver's byte stream (`rx_dv`/`rx_byte`) and parses a sync/length/payload/checksum frame. Completed little-endian 32-bit words go to the memory write port, and the processor is held until a frame is received with a good checksum. It replaces ad-hoc free-running byte counting, so a dropped or spurious byte cannot permanently misalign instruction words.

## Interface
- `ADDR_W`, 8, instruction memory address width; max frame length is min(255, 2^ADDR_W) words
- `TIMEOUT_CYCLES`, 1_041_600, idle cycles allowed between bytes inside a frame (≈10 byte times at 9600 baud, 100 MHz)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `rx_dv`  in  1  one-cycle strobe: `rx_byte` valid
- `rx_byte`  in  8  received byte
- `mem_we`  out  1  one-cycle write strobe to instruction memory
- `mem_addr`  out  ADDR_W  word write address
- `mem_din`  out  32  word write data
- `cpu_hold`  out  1  1 = keep processor/PC in reset
- `load_done`  out  1  one-cycle pulse: frame accepted
- `load_err`  out  1  sticky: last frame failed
- `words_loaded`  out  ADDR_W+1  words written by the current/last frame

## Operation
- Frame format: `0xA5` sync, count byte N, 4·N payload bytes (byte 0 → bits [7:0] … byte 3 → [31:24]), checksum byte.
  - Checksum = XOR of N and all payload bytes.
- States: IDLE, COUNT, DATA, CSUM.
- IDLE:
  - Any byte other than `0xA5` is ignored.
  - On `0xA5`: clear `load_err`, `words_loaded`, the byte index, and the running XOR; set `cpu_hold`=1; go to COUNT.
- COUNT:
  - If N > 2^ADDR_W: set `load_err`, go to IDLE.
  - If N = 0: go to CSUM.
  - Otherwise: latch N, XOR ← N, go to DATA.
- DATA:
  - Each byte is placed into the assembly register at byte index 0..3 and XORed into the running checksum.
  - On index 3: issue a write at address `words_loaded`, then increment `words_loaded`.
  - After word N: go to CSUM.
- CSUM:
  - Match: pulse `load_done`, set `cpu_hold`=0, go to IDLE.
  - Mismatch: set `load_err`, keep `cpu_hold`=1, go to IDLE.
- Writes are committed as words complete and are not rolled back on error. `cpu_hold` remaining 1 makes a failed load harmless.
- Timeout:
  - In any state except IDLE, a counter increments each cycle without `rx_dv` and clears on `rx_dv`.
  - At `TIMEOUT_CYCLES`: set `load_err`, go to IDLE, `cpu_hold` stays 1.
- A sync byte arriving inside DATA is treated as payload; there is no resync mid-frame.
- The word index never wraps, because the length is checked in COUNT.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_din`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0, `words_loaded`=0, state IDLE.
- Reset is asynchronous. Deassertion mid-frame leaves the block in IDLE with the defaults above.
- All outputs are registered.
- Write timing: for the `rx_dv` of payload byte 3 at cycle t:
  - `mem_we`=1 at t+1, for exactly one cycle.
  - `mem_addr` and `mem_din` are valid in the same cycle.
  - `words_loaded` shows the incremented value at t+1.
- Checksum `rx_dv` at cycle t: `load_done` is high at t+1 only; `cpu_hold` falls at t+1, or `load_err` rises at t+1.
- `rx_dv` may be asserted on consecutive cycles. Every strobe is consumed and none is dropped.
- `mem_din` holds its value between writes.

## Test plan
- Reset: assert `reset`=0 mid-operation.
  - Required: `cpu_hold`=1 and all other outputs 0.
  - Release, then feed `0x13`: no state change, `mem_we` never pulses.
- Good frame `A5 02 13 00 00 00 93 00 10 00 92`:
  - Writes addr0=`0x00000013`, then addr1=`0x00100093`, each one-cycle `mem_we`.
  - `load_done` pulses once, `cpu_hold`=0, `words_loaded`=2, `load_err`=0.
- Same frame with checksum `93`:
  - Both writes occur, `load_err`=1, `cpu_hold`=1, no `load_done`.
  - A following good frame clears `load_err` on its sync byte.
- Garbage `FF 00 13` then the good frame: garbage ignored, result identical to the good-frame case.
- Timeout: `A5 01 13 00` then silence.
  - Exactly `TIMEOUT_CYCLES` later (use a small parameter in the bench): `load_err`=1, state IDLE, no write.
- Boundary: with `ADDR_W`=2, frame count `05` → `load_err` after the count byte.
  - Frame count `00` with checksum `00` → `load_done`, `words_loaded`=0.
  - Back-to-back `rx_dv` on every cycle of a 4-word frame → all 4 words written.
